y_fetch_seq: RTL and testbench

Parametrised multi-cycle fetch sequencer, the successor to the combinational `yPC` next-PC mux. It holds the program counter in a register and runs a FETCH/EXEC handshake with instruction memory, so memory may take any number of cycles to respond. It redirects to `entryPoint` on `INT`, saves the interrupted PC, supports pipeline stall, and counts retired instructions. It sits between `yIF` (which it supplies with `PC`) and the datapath branch/jump decode from `yC1` and `yEX`.

---
 rtl/y_fetch_seq.sv | 147 ++++++++++++++
 tb/tb_y_fetch_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y_fetch_seq.sv
// y_fetch_seq
//    Multi-cycle fetch sequencer. Holds the program counter, runs a
//    FETCH/EXEC handshake with instruction memory, handles interrupt
//    redirection with a saved PC, supports stall, and counts retired
//    instructions.
//
// Parameters
//    AW         PC / address width (8..32)
//    RESET_VEC  PC value after reset
//    CW         retired-instruction counter width
//
// Ports
//    clk, reset      clock, synchronous active-high reset
//    INT, entryPoint interrupt request and its vector
//    imm, jTarget    branch offset (words, sign-extended) and jump field
//    zero, branch,   branch/jump decode from the datapath
//    jump
//    stall           hold the current instruction in EXEC
//    mem_ready       instruction memory has the word at PC
//    PC, PCp4        current instruction address and PC+4
//    fetch_req       memory request (FETCH state)
//    ins_valid       instruction executes and commits (EXEC state)
//    epc             PC saved at the last interrupt
//    retired         completed-instruction count (wraps)

module y_fetch_seq #(
   parameter int unsigned AW        = 32,
   parameter int unsigned RESET_VEC = 128,
   parameter int unsigned CW        = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          INT,
   input  logic [AW-1:0] entryPoint,
   input  logic [31:0]   imm,
   input  logic [25:0]   jTarget,
   input  logic          zero,
   input  logic          branch,
   input  logic          jump,
   input  logic          stall,
   input  logic          mem_ready,
   output logic [AW-1:0] PC,
   output logic [AW-1:0] PCp4,
   output logic          fetch_req,
   output logic          ins_valid,
   output logic [AW-1:0] epc,
   output logic [CW-1:0] retired
);

   typedef enum logic [1:0] {
      S_RST   = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_e;

   state_e        state_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] epc_q;
   logic [CW-1:0] retired_q;
   logic          fetch_req_q;
   logic          ins_valid_q;

   logic [AW-1:0] pcp4;
   logic [31:0]   pcp4z;
   logic [31:0]   br_off;
   logic [31:0]   br_tgt;
   logic [31:0]   j_tgt;
   logic [AW-1:0] next_pc_d;

   assign pcp4 = pc_q + AW'(4);

   // Branch and jump targets are formed at 32 bits, then truncated to AW.
   always_comb begin
      pcp4z         = '0;
      pcp4z[AW-1:0] = pcp4;
   end

   assign br_off = imm << 2;
   assign br_tgt = pcp4z + br_off;
   assign j_tgt  = {pcp4z[31:28], jTarget, 2'b00};

   always_comb begin
      next_pc_d = pcp4;
      if (jump) begin
         next_pc_d = j_tgt[AW-1:0];
      end else if (branch && zero) begin
         next_pc_d = br_tgt[AW-1:0];
      end
   end

   // Outputs are registered alongside the state so they always decode the
   // state being entered; fetch_req and ins_valid are never both set.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_RST;
         pc_q        <= AW'(RESET_VEC);
         epc_q       <= '0;
         retired_q   <= '0;
         fetch_req_q <= 1'b0;
         ins_valid_q <= 1'b0;
      end else if (INT) begin
         // Abandon whatever is in flight; it is not retired.
         epc_q       <= pc_q;
         pc_q        <= entryPoint;
         state_q     <= S_FETCH;
         fetch_req_q <= 1'b1;
         ins_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_RST: begin
               state_q     <= S_FETCH;
               fetch_req_q <= 1'b1;
               ins_valid_q <= 1'b0;
            end
            S_FETCH: begin
               if (mem_ready) begin
                  state_q     <= S_EXEC;
                  fetch_req_q <= 1'b0;
                  ins_valid_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  pc_q        <= next_pc_d;
                  retired_q   <= retired_q + CW'(1);
                  state_q     <= S_FETCH;
                  fetch_req_q <= 1'b1;
                  ins_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_RST;
               fetch_req_q <= 1'b0;
               ins_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign PC        = pc_q;
   assign PCp4      = pcp4;
   assign fetch_req = fetch_req_q;
   assign ins_valid = ins_valid_q;
   assign epc       = epc_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_y_fetch_seq.sv
// tb_y_fetch_seq
//    Bench for y_fetch_seq. Instance A uses the default widths
//    (AW=32, CW=16); instance B uses AW=8, CW=2 for truncation and
//    counter wrap. Both share the input bus; the idle instance is held
//    in reset and sel picks which one is observed. Each instruction
//    issued pushes its expected PC/retired/epc; the monitor pops one
//    entry each time fetch_req rises.

module tb_y_fetch_seq;

   logic        clk;
   logic        rst_a, rst_b;
   logic        INT;
   logic [31:0] entryPoint;
   logic [31:0] imm;
   logic [25:0] jTarget;
   logic        zero, branch, jump, stall, mem_ready;
   logic        sel;

   logic [31:0] pc_a, pcp4_a, epc_a;
   logic [15:0] ret_a;
   logic        fr_a, iv_a;
   logic [7:0]  pc_b, pcp4_b, epc_b;
   logic [1:0]  ret_b;
   logic        fr_b, iv_b;

   logic [31:0] pc_m, pcp4_m, epc_m, ret_m;
   logic        fr_m, iv_m;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ret;
      logic [31:0] epc;
   } exp_t;

   exp_t        expq[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_ret;
   logic [31:0] exp_epc;

   y_fetch_seq #(.AW(32), .RESET_VEC(128), .CW(16)) u_dut_a (
      .clk(clk), .reset(rst_a), .INT(INT), .entryPoint(entryPoint),
      .imm(imm), .jTarget(jTarget), .zero(zero), .branch(branch),
      .jump(jump), .stall(stall), .mem_ready(mem_ready),
      .PC(pc_a), .PCp4(pcp4_a), .fetch_req(fr_a), .ins_valid(iv_a),
      .epc(epc_a), .retired(ret_a)
   );

   y_fetch_seq #(.AW(8), .RESET_VEC(128), .CW(2)) u_dut_b (
      .clk(clk), .reset(rst_b), .INT(INT), .entryPoint(entryPoint[7:0]),
      .imm(imm), .jTarget(jTarget), .zero(zero), .branch(branch),
      .jump(jump), .stall(stall), .mem_ready(mem_ready),
      .PC(pc_b), .PCp4(pcp4_b), .fetch_req(fr_b), .ins_valid(iv_b),
      .epc(epc_b), .retired(ret_b)
   );

   assign pc_m   = sel ? 32'(pc_b)   : pc_a;
   assign pcp4_m = sel ? 32'(pcp4_b) : pcp4_a;
   assign epc_m  = sel ? 32'(epc_b)  : epc_a;
   assign ret_m  = sel ? 32'(ret_b)  : 32'(ret_a);
   assign fr_m   = sel ? fr_b : fr_a;
   assign iv_m   = sel ? iv_b : iv_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: one expectation per FETCH entry.
   initial begin
      logic fr_prev;
      exp_t e;
      fr_prev = 1'b0;
      forever begin
         @(negedge clk);
         chk("moore_exclusive", 32'(fr_m & iv_m), 32'd0);
         if (fr_m === 1'b1 && fr_prev !== 1'b1) begin
            if (expq.size() == 0) begin
               chk("unexpected_fetch", pc_m, 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               chk("fetch_pc", pc_m, e.pc);
               chk("fetch_retired", ret_m, e.ret);
               chk("fetch_epc", epc_m, e.epc);
            end
         end
         fr_prev = fr_m;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic set_rst(input logic v);
      if (sel) rst_b = v;
      else     rst_a = v;
   endtask

   task automatic bump_ret();
      exp_ret = sel ? ((exp_ret + 1) % 4) : ((exp_ret + 1) % 65536);
   endtask

   // Called at a negedge; leaves the bench at the negedge where FETCH begins.
   task automatic do_reset(input logic [31:0] rv);
      set_rst(1'b1);
      repeat (2) @(negedge clk);
      chk("rst_pc", pc_m, rv);
      chk("rst_pcp4", pcp4_m, sel ? ((rv + 4) & 32'hFF) : rv + 4);
      chk("rst_fetch_req", 32'(fr_m), 32'd0);
      chk("rst_ins_valid", 32'(iv_m), 32'd0);
      chk("rst_epc", epc_m, 32'd0);
      chk("rst_retired", ret_m, 32'd0);
      exp_ret = 0;
      exp_epc = 0;
      expq.push_back('{rv, 32'd0, 32'd0});
      set_rst(1'b0);
      @(negedge clk);
      chk("first_fetch_req", 32'(fr_m), 32'd1);
   endtask

   // One instruction from the FETCH negedge to the next FETCH negedge.
   task automatic run_instr(input int waits, input int stalls,
                            input logic j, input logic br, input logic z,
                            input logic [31:0] im, input logic [25:0] jt,
                            input logic [31:0] exp_next,
                            output int held, output int ivc);
      logic [31:0] pc0;
      pc0  = pc_m;
      held = 0;
      ivc  = 0;
      for (int i = 0; i < waits; i++) begin
         mem_ready = 1'b0;
         held += (pc_m == pc0) ? 1 : 0; ivc += int'(iv_m);
         @(negedge clk);
      end
      mem_ready = 1'b1;
      held += (pc_m == pc0) ? 1 : 0; ivc += int'(iv_m);
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < stalls; i++) begin
         stall = 1'b1;
         held += (pc_m == pc0) ? 1 : 0; ivc += int'(iv_m);
         @(negedge clk);
      end
      stall = 1'b0; jump = j; branch = br; zero = z; imm = im; jTarget = jt;
      held += (pc_m == pc0) ? 1 : 0; ivc += int'(iv_m);
      bump_ret();
      expq.push_back('{exp_next, exp_ret, exp_epc});
      @(negedge clk);
      jump = 1'b0; branch = 1'b0; zero = 1'b0; imm = '0; jTarget = '0;
   endtask

   initial begin
      int h, v;
      sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; INT = 1'b0;
      entryPoint = '0; imm = '0; jTarget = '0;
      zero = 1'b0; branch = 1'b0; jump = 1'b0; stall = 1'b0; mem_ready = 1'b0;
      exp_ret = 0; exp_epc = 0;
      @(negedge clk);

      // Straight-line run
      do_reset(32'd128);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd132, h, v);
      chk("straight_held", 32'(h), 32'd2);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd136, h, v);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd140, h, v);
      chk("straight_retired", ret_m, 32'd3);

      // Memory wait and stall
      do_reset(32'd128);
      run_instr(3, 2, 0, 0, 0, 0, 0, 32'd132, h, v);
      chk("wait_pc_held", 32'(h), 32'd7);
      chk("wait_ins_valid_cycles", 32'(v), 32'd3);
      chk("wait_retired", ret_m, 32'd1);

      // Branch taken / not taken
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd136, h, v);
      run_instr(0, 0, 0, 1, 1, -32'sd3, 0, 32'd128, h, v);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd132, h, v);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd136, h, v);
      run_instr(0, 0, 0, 1, 0, -32'sd3, 0, 32'd140, h, v);

      // Interrupt during a stalled jump in EXEC at PC=140
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      stall = 1'b1; jump = 1'b1; jTarget = 26'h3; INT = 1'b1; entryPoint = 32'd256;
      exp_epc = 32'd140;
      expq.push_back('{32'd256, exp_ret, 32'd140});
      @(negedge clk);
      INT = 1'b0; stall = 1'b0; jump = 1'b0; jTarget = '0;
      chk("int_fetch_req", 32'(fr_m), 32'd1);
      chk("int_ins_valid", 32'(iv_m), 32'd0);
      chk("int_epc", epc_m, 32'd140);

      // Jumps, including jump priority over a taken branch
      run_instr(0, 0, 1, 0, 0, 0, 26'h50, 32'h140, h, v);
      run_instr(0, 0, 1, 1, 1, 32'd5, 26'h40, 32'h100, h, v);

      // Reset together with INT in the middle of EXEC
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      rst_a = 1'b1; INT = 1'b1; entryPoint = 32'd256; jump = 1'b1;
      @(negedge clk);
      INT = 1'b0; jump = 1'b0;
      chk("rstint_pc", pc_m, 32'd128);
      chk("rstint_epc", epc_m, 32'd0);
      chk("rstint_retired", ret_m, 32'd0);
      chk("rstint_ins_valid", 32'(iv_m), 32'd0);
      exp_ret = 0; exp_epc = 0;
      expq.push_back('{32'd128, 32'd0, 32'd0});
      rst_a = 1'b0;
      @(negedge clk);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'd132, h, v);

      // Narrow instance: truncation and counter wrap
      rst_a = 1'b1;
      sel   = 1'b1;
      @(negedge clk);
      do_reset(32'h80);
      run_instr(0, 0, 1, 0, 0, 0, 26'h7F, 32'hFC, h, v);
      chk("aw8_pcp4_wrap", pcp4_m, 32'h00);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'h00, h, v);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'h04, h, v);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'h08, h, v);
      chk("cw2_wrap_zero", ret_m, 32'd0);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'h0C, h, v);
      chk("cw2_after_wrap", ret_m, 32'd1);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
